// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three per-source result FIFOs (ALU, LSB, BRU) drained
// round-robin, one result per cycle, onto a registered broadcast. Tag 0 means idle.
module cdb_arbiter #(
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int Q_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_alu_valid,
    input  logic [TAG_W-1:0]  in_alu_tag,
    input  logic [DATA_W-1:0] in_alu_value,
    output logic              out_alu_ready,
    input  logic              in_lsb_valid,
    input  logic [TAG_W-1:0]  in_lsb_tag,
    input  logic [DATA_W-1:0] in_lsb_value,
    input  logic              in_lsb_ioin,
    output logic              out_lsb_ready,
    input  logic              in_bru_valid,
    input  logic [TAG_W-1:0]  in_bru_tag,
    input  logic [DATA_W-1:0] in_bru_value,
    output logic              out_bru_ready,
    input  logic              in_rob_misbranch,
    output logic [TAG_W-1:0]  out_cdb_tag,
    output logic [DATA_W-1:0] out_cdb_value,
    output logic              out_cdb_ioin
);

    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NSRC  = 3;

    localparam logic [1:0]        SRC_ALU  = 2'd0;
    localparam logic [1:0]        SRC_LSB  = 2'd1;
    localparam logic [1:0]        SRC_BRU  = 2'd2;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(Q_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [TAG_W-1:0]  TAG_NULL = {TAG_W{1'b0}};

    logic [TAG_W-1:0]  q_tag_r   [NSRC][Q_DEPTH];
    logic [DATA_W-1:0] q_value_r [NSRC][Q_DEPTH];
    logic              lsb_ioin_r [Q_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r  [NSRC];
    logic [PTR_W-1:0]  rd_ptr_r  [NSRC];
    logic [CNT_W-1:0]  count_r   [NSRC];
    logic [1:0]        rr_ptr_r;
    logic [TAG_W-1:0]  cdb_tag_r;
    logic [DATA_W-1:0] cdb_value_r;
    logic              cdb_ioin_r;

    logic [NSRC-1:0]   in_valid_s;
    logic [TAG_W-1:0]  in_tag_s   [NSRC];
    logic [DATA_W-1:0] in_value_s [NSRC];
    logic [NSRC-1:0]   ready_s;
    logic [NSRC-1:0]   nonempty_s;
    logic [NSRC-1:0]   push_s;
    logic [NSRC-1:0]   pop_s;
    logic              grant_vld_s;
    logic [1:0]        grant_idx_s;
    logic [1:0]        cand1_s;
    logic [1:0]        cand2_s;
    logic [TAG_W-1:0]  head_tag_s;
    logic [DATA_W-1:0] head_value_s;
    logic              head_ioin_s;

    function automatic logic [1:0] next_src(input logic [1:0] src);
        logic [1:0] nxt;
        case (src)
            SRC_ALU: nxt = SRC_LSB;
            SRC_LSB: nxt = SRC_BRU;
            default: nxt = SRC_ALU;
        endcase
        return nxt;
    endfunction

    assign in_valid_s    = {in_bru_valid, in_lsb_valid, in_alu_valid};
    assign in_tag_s[0]   = in_alu_tag;
    assign in_tag_s[1]   = in_lsb_tag;
    assign in_tag_s[2]   = in_bru_tag;
    assign in_value_s[0] = in_alu_value;
    assign in_value_s[1] = in_lsb_value;
    assign in_value_s[2] = in_bru_value;

    // Round-robin pick among non-empty heads, starting at rr_ptr_r
    always_comb begin
        cand1_s     = next_src(rr_ptr_r);
        cand2_s     = next_src(cand1_s);
        grant_vld_s = 1'b1;
        grant_idx_s = rr_ptr_r;
        if (nonempty_s[rr_ptr_r]) begin
            grant_idx_s = rr_ptr_r;
        end else if (nonempty_s[cand1_s]) begin
            grant_idx_s = cand1_s;
        end else if (nonempty_s[cand2_s]) begin
            grant_idx_s = cand2_s;
        end else begin
            grant_vld_s = 1'b0;
            grant_idx_s = rr_ptr_r;
        end
    end

    // Per-source occupancy flags and push/pop qualification
    always_comb begin
        ready_s    = {NSRC{1'b0}};
        nonempty_s = {NSRC{1'b0}};
        push_s     = {NSRC{1'b0}};
        pop_s      = {NSRC{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            ready_s[i]    = (count_r[i] != CNT_FULL);
            nonempty_s[i] = (count_r[i] != CNT_ZERO);
            push_s[i]     = in_valid_s[i] && ready_s[i] && (in_tag_s[i] != TAG_NULL)
                            && !in_rob_misbranch;
            pop_s[i]      = grant_vld_s && (grant_idx_s == 2'(i));
        end
    end

    // Head entry of the granted source; ioin only exists for the LSB queue
    always_comb begin
        head_tag_s   = q_tag_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
        head_value_s = q_value_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
        if (grant_idx_s == SRC_LSB) begin
            head_ioin_s = lsb_ioin_r[rd_ptr_r[1]];
        end else begin
            head_ioin_s = 1'b0;
        end
    end

    // FIFO payload storage; no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (rst && rdy) begin
            for (int i = 0; i < NSRC; i++) begin
                if (push_s[i]) begin
                    q_tag_r[i][wr_ptr_r[i]]   <= in_tag_s[i];
                    q_value_r[i][wr_ptr_r[i]] <= in_value_s[i];
                end
            end
            if (push_s[1]) begin
                lsb_ioin_r[wr_ptr_r[1]] <= in_lsb_ioin;
            end
        end
    end

    // Queue pointers, round-robin pointer and the registered broadcast
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NSRC; i++) begin
                wr_ptr_r[i] <= PTR_ZERO;
                rd_ptr_r[i] <= PTR_ZERO;
                count_r[i]  <= CNT_ZERO;
            end
            rr_ptr_r    <= SRC_ALU;
            cdb_tag_r   <= TAG_NULL;
            cdb_value_r <= {DATA_W{1'b0}};
            cdb_ioin_r  <= 1'b0;
        end else if (rdy) begin
            if (in_rob_misbranch) begin
                for (int i = 0; i < NSRC; i++) begin
                    wr_ptr_r[i] <= PTR_ZERO;
                    rd_ptr_r[i] <= PTR_ZERO;
                    count_r[i]  <= CNT_ZERO;
                end
                cdb_tag_r  <= TAG_NULL;
                cdb_ioin_r <= 1'b0;
            end else begin
                for (int i = 0; i < NSRC; i++) begin
                    if (push_s[i]) begin
                        wr_ptr_r[i] <= wr_ptr_r[i] + PTR_ONE;
                    end
                    if (pop_s[i]) begin
                        rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
                    end
                    case ({push_s[i], pop_s[i]})
                        2'b10:   count_r[i] <= count_r[i] + CNT_ONE;
                        2'b01:   count_r[i] <= count_r[i] - CNT_ONE;
                        default: count_r[i] <= count_r[i];
                    endcase
                end
                if (grant_vld_s) begin
                    cdb_tag_r   <= head_tag_s;
                    cdb_value_r <= head_value_s;
                    cdb_ioin_r  <= head_ioin_s;
                    rr_ptr_r    <= next_src(grant_idx_s);
                end else begin
                    cdb_tag_r  <= TAG_NULL;
                    cdb_ioin_r <= 1'b0;
                end
            end
        end
    end

    assign out_alu_ready = ready_s[0];
    assign out_lsb_ready = ready_s[1];
    assign out_bru_ready = ready_s[2];
    assign out_cdb_tag   = cdb_tag_r;
    assign out_cdb_value = cdb_value_r;
    assign out_cdb_ioin  = cdb_ioin_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table followed by random traffic
// compared against a queue-based reference model.
module tb_cdb_arbiter;
    localparam int TAG_W = 4;
    localparam int DATA_W = 32;
    localparam int QD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, rdy, mis;
    logic              alu_v, lsb_v, bru_v, lsb_io;
    logic [TAG_W-1:0]  alu_t, lsb_t, bru_t;
    logic [DATA_W-1:0] alu_d, lsb_d, bru_d;
    logic              alu_rdy, lsb_rdy, bru_rdy;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_val;
    logic              cdb_io;

    int checks = 0;
    int failures = 0;

    cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .Q_DEPTH(QD)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_alu_valid(alu_v), .in_alu_tag(alu_t), .in_alu_value(alu_d), .out_alu_ready(alu_rdy),
        .in_lsb_valid(lsb_v), .in_lsb_tag(lsb_t), .in_lsb_value(lsb_d), .in_lsb_ioin(lsb_io),
        .out_lsb_ready(lsb_rdy),
        .in_bru_valid(bru_v), .in_bru_tag(bru_t), .in_bru_value(bru_d), .out_bru_ready(bru_rdy),
        .in_rob_misbranch(mis),
        .out_cdb_tag(cdb_tag), .out_cdb_value(cdb_val), .out_cdb_ioin(cdb_io)
    );

    typedef struct {
        logic r, rd, m;
        logic av; logic [3:0] at; logic [31:0] ad;
        logic lv; logic [3:0] lt; logic [31:0] ld; logic li;
        logic bv; logic [3:0] bt; logic [31:0] bd;
        logic [3:0] e_tag; logic [31:0] e_val; logic e_io; logic [2:0] e_rdy;
    } vec_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        logic        io;
    } ent_t;

    vec_t tbl[$];
    ent_t mq0[$], mq1[$], mq2[$];
    int m_rr;
    logic [3:0]  m_tag;
    logic [31:0] m_val;
    logic        m_io;

    function automatic vec_t mk(input logic r, input logic rd, input logic m,
                                input logic av, input logic [3:0] at, input logic [31:0] ad,
                                input logic lv, input logic [3:0] lt, input logic [31:0] ld,
                                input logic li,
                                input logic bv, input logic [3:0] bt, input logic [31:0] bd,
                                input logic [3:0] et, input logic [31:0] ev, input logic eio,
                                input logic [2:0] erdy);
        vec_t v;
        v.r = r; v.rd = rd; v.m = m;
        v.av = av; v.at = at; v.ad = ad;
        v.lv = lv; v.lt = lt; v.ld = ld; v.li = li;
        v.bv = bv; v.bt = bt; v.bd = bd;
        v.e_tag = et; v.e_val = ev; v.e_io = eio; v.e_rdy = erdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.r; rdy = v.rd; mis = v.m;
        alu_v = v.av; alu_t = v.at; alu_d = v.ad;
        lsb_v = v.lv; lsb_t = v.lt; lsb_d = v.ld; lsb_io = v.li;
        bru_v = v.bv; bru_t = v.bt; bru_d = v.bd;
    endtask

    function automatic int msize(input int s);
        case (s)
            0:       return mq0.size();
            1:       return mq1.size();
            default: return mq2.size();
        endcase
    endfunction

    // Reference behaviour at one rising edge, using the inputs currently driven
    task automatic model_edge();
        bit a0, a1, a2;
        int g;
        ent_t e;
        if (!rst) begin
            mq0.delete(); mq1.delete(); mq2.delete();
            m_rr = 0; m_tag = 4'd0; m_val = 32'd0; m_io = 1'b0;
        end else if (rdy) begin
            if (mis) begin
                mq0.delete(); mq1.delete(); mq2.delete();
                m_tag = 4'd0; m_io = 1'b0;
            end else begin
                a0 = alu_v && (mq0.size() < QD) && (alu_t != 4'd0);
                a1 = lsb_v && (mq1.size() < QD) && (lsb_t != 4'd0);
                a2 = bru_v && (mq2.size() < QD) && (bru_t != 4'd0);
                g = -1;
                for (int k = 0; k < 3; k++) begin
                    if (g < 0 && msize((m_rr + k) % 3) > 0) g = (m_rr + k) % 3;
                end
                if (g >= 0) begin
                    if (g == 0) e = mq0.pop_front();
                    else if (g == 1) e = mq1.pop_front();
                    else e = mq2.pop_front();
                    m_tag = e.tag; m_val = e.val; m_io = e.io;
                    m_rr = (g + 1) % 3;
                end else begin
                    m_tag = 4'd0; m_io = 1'b0;
                end
                if (a0) mq0.push_back('{alu_t, alu_d, 1'b0});
                if (a1) mq1.push_back('{lsb_t, lsb_d, lsb_io});
                if (a2) mq2.push_back('{bru_t, bru_d, 1'b0});
            end
        end
    endtask

    initial begin
        vec_t idle;
        idle = mk(1,1,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0,0,3'b111);
        drive(idle);
        // r rd m | alu v,t,d | lsb v,t,d,io | bru v,t,d | exp tag,val,io,rdy{alu,lsb,bru}
        tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,0,       0,0,0,       0,32'h00,0,3'b111));
        tbl.push_back(mk(1,1,0, 1,3,32'h10, 0,0,0,0,       0,0,0,       0,32'h00,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       3,32'h10,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       0,32'h10,0,3'b111));
        tbl.push_back(mk(0,1,0, 0,0,0,      0,0,0,0,       0,0,0,       0,32'h00,0,3'b111));
        tbl.push_back(mk(1,1,0, 1,1,32'hA1, 1,2,32'hB2,0,  1,3,32'hC3,  0,32'h00,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       1,32'hA1,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       2,32'hB2,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       3,32'hC3,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       0,32'hC3,0,3'b111));
        tbl.push_back(mk(1,1,0, 1,1,32'h11, 1,4,32'h44,0,  1,9,32'h99,  0,32'hC3,0,3'b111));
        tbl.push_back(mk(1,1,0, 1,2,32'h22, 1,5,32'h55,0,  1,10,32'hAA, 1,32'h11,0,3'b100));
        tbl.push_back(mk(1,1,0, 0,0,0,      1,6,32'h66,0,  0,0,0,       4,32'h44,0,3'b110));
        tbl.push_back(mk(1,1,0, 0,0,0,      1,6,32'h66,0,  0,0,0,       9,32'h99,0,3'b101));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       2,32'h22,0,3'b101));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       5,32'h55,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,      10,32'hAA,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       6,32'h66,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       0,32'h66,0,3'b111));
        tbl.push_back(mk(1,1,0, 1,7,32'h77, 0,0,0,0,       1,8,32'h88,  0,32'h66,0,3'b111));
        tbl.push_back(mk(1,1,1, 0,0,0,      1,11,32'hBB,0, 0,0,0,       0,32'h66,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       0,32'h66,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       0,32'h66,0,3'b111));
        tbl.push_back(mk(1,1,0, 1,12,32'hC0,0,0,0,0,       0,0,0,       0,32'h66,0,3'b111));
        tbl.push_back(mk(1,1,0, 1,5,32'h5A, 0,0,0,0,       0,0,0,      12,32'hC0,0,3'b111));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1,0,0, 0,0,0,  0,0,0,0,       1,3,32'h33, 12,32'hC0,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       5,32'h5A,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       0,32'h5A,0,3'b111));
        tbl.push_back(mk(1,1,0, 1,0,32'hEE, 1,7,32'h77,1,  0,0,0,       0,32'h5A,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       7,32'h77,1,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       0,32'h77,0,3'b111));
        tbl.push_back(mk(1,1,0, 1,2,32'h12, 0,0,0,0,       0,0,0,       0,32'h77,0,3'b111));
        tbl.push_back(mk(0,1,0, 1,3,32'h13, 0,0,0,0,       1,4,32'h34,  0,32'h00,0,3'b111));
        tbl.push_back(mk(1,1,0, 0,0,0,      0,0,0,0,       0,0,0,       0,32'h00,0,3'b111));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_tag", i), 32'(cdb_tag), 32'(tbl[i].e_tag));
            chk($sformatf("vec%0d_val", i), cdb_val, tbl[i].e_val);
            chk($sformatf("vec%0d_ioin", i), 32'(cdb_io), 32'(tbl[i].e_io));
            chk($sformatf("vec%0d_ready", i), 32'({alu_rdy, lsb_rdy, bru_rdy}),
                32'(tbl[i].e_rdy));
        end

        // Random traffic; cycles 800..1199 keep every source loaded to exercise rotation
        for (int c = 0; c < 2500; c++) begin
            bit busy;
            busy  = (c >= 800) && (c < 1200);
            rst   = (c == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            rdy   = busy ? 1'b1 : ($urandom_range(0, 7) != 0);
            mis   = busy ? 1'b0 : ($urandom_range(0, 19) == 0);
            alu_v = busy ? 1'b1 : ($urandom_range(0, 9) < 6);
            lsb_v = busy ? 1'b1 : ($urandom_range(0, 9) < 6);
            bru_v = busy ? 1'b1 : ($urandom_range(0, 9) < 6);
            alu_t = busy ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
            lsb_t = busy ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
            bru_t = busy ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
            alu_d = $urandom; lsb_d = $urandom; bru_d = $urandom;
            lsb_io = 1'($urandom_range(0, 1));
            #2;
            if (c > 0) begin
                chk("rnd_alu_ready", 32'(alu_rdy), 32'(mq0.size() < QD));
                chk("rnd_lsb_ready", 32'(lsb_rdy), 32'(mq1.size() < QD));
                chk("rnd_bru_ready", 32'(bru_rdy), 32'(mq2.size() < QD));
            end
            @(posedge clk);
            model_edge();
            #1;
            chk("rnd_tag", 32'(cdb_tag), 32'(m_tag));
            chk("rnd_val", cdb_val, m_val);
            chk("rnd_ioin", 32'(cdb_io), 32'(m_io));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
